// File: rtl/std_cache_pkg.sv
// ---------------------------------------------------------------------------
// std_cache_pkg: shared dcache defaults and the flush-walk FSM encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package std_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC = 8;
  localparam int unsigned DCACHE_NUM_SETS  = 256;

  typedef enum logic [2:0] {
    FL_IDLE    = 3'd0,
    FL_RD      = 3'd1,
    FL_RDATA   = 3'd2,
    FL_WB      = 3'd3,
    FL_WB_WAIT = 3'd4,
    FL_INV     = 3'd5,
    FL_DONE    = 3'd6,
    FL_HOLD    = 3'd7
  } flush_state_e;

endpackage

`default_nettype wire

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter: clearable up-counter; STICKY_OVERFLOW=1 saturates at all-ones.
// Only built when DCACHE_FLUSH_PERF_EN is defined (sole user is the flush unit).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef DCACHE_FLUSH_PERF_EN
module counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (!(STICKY_OVERFLOW && (&cnt_q))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule
`endif

`default_nettype wire

// File: rtl/dcache_flush_unit.sv
// ---------------------------------------------------------------------------
// dcache_flush_unit: walks every set/way on a flush request, writing back
// dirty lines and invalidating valid ones, then pulses flush_ack_o.
// Optional perf counters: DCACHE_FLUSH_PERF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_flush_unit
  import std_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS  = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS  = DCACHE_SET_ASSOC,
  parameter int unsigned TAG_WIDTH = 44,
  localparam int unsigned SET_W    = $clog2(NUM_SETS),
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned IDX_W    = SET_W + WAY_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  output logic                 flush_ack_o,
  output logic                 busy_o,
`ifdef DCACHE_FLUSH_PERF_EN
  output logic [31:0]          perf_wb_cnt_o,
  output logic [31:0]          perf_cycles_o,
`endif
  output logic                 arr_req_o,
  input  logic                 arr_gnt_i,
  output logic                 arr_we_o,
  output logic [SET_W-1:0]     arr_set_o,
  output logic [WAY_W-1:0]     arr_way_o,
  input  logic                 arr_rvalid_i,
  input  logic                 arr_rdirty_i,
  input  logic [TAG_WIDTH-1:0] arr_rtag_i,
  output logic                 wb_req_o,
  input  logic                 wb_gnt_i,
  output logic [SET_W-1:0]     wb_set_o,
  output logic [WAY_W-1:0]     wb_way_o,
  output logic [TAG_WIDTH-1:0] wb_tag_o,
  input  logic                 wb_done_i
);

  flush_state_e         state_d, state_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [TAG_WIDTH-1:0] tag_d, tag_q;
  logic                 last_idx;

  assign last_idx = &idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    flush_ack_o = 1'b0;
    arr_req_o   = 1'b0;
    arr_we_o    = 1'b0;
    wb_req_o    = 1'b0;
    unique case (state_q)
      FL_IDLE: begin
        if (flush_i) begin
          state_d = FL_RD;
          idx_d   = '0;
        end
      end
      FL_RD: begin
        arr_req_o = 1'b1;
        if (arr_gnt_i) state_d = FL_RDATA;
      end
      FL_RDATA: begin
        tag_d = arr_rtag_i;
        if (arr_rvalid_i && arr_rdirty_i) begin
          state_d = FL_WB;
        end else if (arr_rvalid_i) begin
          state_d = FL_INV;
        end else if (last_idx) begin
          state_d = FL_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FL_RD;
        end
      end
      FL_WB: begin
        wb_req_o = 1'b1;
        // A commit can already be reported in the same cycle as the grant.
        if (wb_gnt_i) state_d = wb_done_i ? FL_INV : FL_WB_WAIT;
      end
      FL_WB_WAIT: begin
        if (wb_done_i) state_d = FL_INV;
      end
      FL_INV: begin
        arr_req_o = 1'b1;
        arr_we_o  = 1'b1;
        if (arr_gnt_i) begin
          if (last_idx) begin
            state_d = FL_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FL_RD;
          end
        end
      end
      FL_DONE: begin
        flush_ack_o = 1'b1;
        state_d     = FL_HOLD;
      end
      FL_HOLD: begin
        if (!flush_i) state_d = FL_IDLE;
      end
      default: state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FL_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
    end
  end

  assign busy_o    = (state_q != FL_IDLE) && (state_q != FL_HOLD);
  assign arr_set_o = idx_q[IDX_W-1:WAY_W];
  assign arr_way_o = idx_q[WAY_W-1:0];
  assign wb_set_o  = idx_q[IDX_W-1:WAY_W];
  assign wb_way_o  = idx_q[WAY_W-1:0];
  assign wb_tag_o  = tag_q;

`ifdef DCACHE_FLUSH_PERF_EN
  logic perf_clear;
  logic perf_wb_inc;

  assign perf_clear  = (state_q == FL_IDLE) && flush_i;
  assign perf_wb_inc = (state_q == FL_WB) && wb_gnt_i;

  counter #(
    .WIDTH          (32),
    .STICKY_OVERFLOW(1'b1)
  ) u_perf_wb_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(perf_clear),
    .en_i   (perf_wb_inc),
    .q_o    (perf_wb_cnt_o)
  );

  counter #(
    .WIDTH          (32),
    .STICKY_OVERFLOW(1'b1)
  ) u_perf_cycles (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(perf_clear),
    .en_i   (busy_o),
    .q_o    (perf_cycles_o)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_flush_unit.sv
// ---------------------------------------------------------------------------
// tb_dcache_flush_unit: table-driven flush scenarios on a 2x2 cache model,
// plus hand-written reset-mid-walk sequence.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dcache_flush_unit;

  localparam int NS = 2;
  localparam int NW = 2;
  localparam int TW = 44;
  localparam int N  = NS * NW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          flush_ack_o;
  logic          busy_o;
  logic          arr_req_o;
  logic          arr_gnt_i;
  logic          arr_we_o;
  logic [0:0]    arr_set_o;
  logic [0:0]    arr_way_o;
  logic          arr_rvalid_i;
  logic          arr_rdirty_i;
  logic [TW-1:0] arr_rtag_i;
  logic          wb_req_o;
  logic          wb_gnt_i;
  logic [0:0]    wb_set_o;
  logic [0:0]    wb_way_o;
  logic [TW-1:0] wb_tag_o;
  logic          wb_done_i;
`ifdef DCACHE_FLUSH_PERF_EN
  logic [31:0]   perf_wb_cnt_o;
  logic [31:0]   perf_cycles_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_flush_unit #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .flush_ack_o (flush_ack_o),
    .busy_o      (busy_o),
`ifdef DCACHE_FLUSH_PERF_EN
    .perf_wb_cnt_o(perf_wb_cnt_o),
    .perf_cycles_o(perf_cycles_o),
`endif
    .arr_req_o   (arr_req_o),
    .arr_gnt_i   (arr_gnt_i),
    .arr_we_o    (arr_we_o),
    .arr_set_o   (arr_set_o),
    .arr_way_o   (arr_way_o),
    .arr_rvalid_i(arr_rvalid_i),
    .arr_rdirty_i(arr_rdirty_i),
    .arr_rtag_i  (arr_rtag_i),
    .wb_req_o    (wb_req_o),
    .wb_gnt_i    (wb_gnt_i),
    .wb_set_o    (wb_set_o),
    .wb_way_o    (wb_way_o),
    .wb_tag_o    (wb_tag_o),
    .wb_done_i   (wb_done_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Tag/state array model, index = set*NW + way
  logic          mv [N];
  logic          md [N];
  logic [TW-1:0] mt [N];

  typedef struct {
    logic [3:0]    valid;
    logic [3:0]    dirty;
    logic [TW-1:0] tag_base;
    int            stall;     // array grant held low this many cycles per access
    int            lat;       // wb_done_i cycles after wb grant
    int            exp_ack;   // cycles from flush-sampling IDLE cycle to ack
    int            exp_wbs;
    int            exp_invs;
  } vec_t;

  vec_t vecs [6];

  task automatic run_flush(input vec_t v, input int id);
    int c, ack_c, acks, wbs, invs, order_err, stab_err, proto_err;
    int stall_cnt, done_cnt, rd_idx, rd_ptr, inv_ptr, wb_ptr, wb_line;
    int cur, wcur, ref_idx, exp_i;
    bit rd_pend, done_act, ref_we;
    bit committed [N];
    logic [3:0] final_valid;
    string tag;
    for (int i = 0; i < N; i++) begin
      mv[i] = v.valid[i];
      md[i] = v.dirty[i];
      mt[i] = v.tag_base + TW'(i);
      committed[i] = 1'b0;
    end
    ack_c = -1; acks = 0; wbs = 0; invs = 0; order_err = 0; stab_err = 0; proto_err = 0;
    stall_cnt = 0; done_cnt = 0; rd_idx = 0; rd_ptr = 0; inv_ptr = 0; wb_ptr = 0; wb_line = 0;
    ref_idx = 0; ref_we = 1'b0; rd_pend = 1'b0; done_act = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b1;
    c = 0;
    while (c < 400) begin
      if (rd_pend) begin
        arr_rvalid_i = mv[rd_idx];
        arr_rdirty_i = md[rd_idx];
        arr_rtag_i   = mt[rd_idx];
        rd_pend      = 1'b0;
      end else begin
        arr_rvalid_i = 1'b0;
        arr_rdirty_i = 1'b0;
        arr_rtag_i   = '0;
      end
      arr_gnt_i = 1'b0;
      wb_gnt_i  = 1'b0;
      wb_done_i = 1'b0;
      cur  = int'(arr_set_o) * NW + int'(arr_way_o);
      wcur = int'(wb_set_o) * NW + int'(wb_way_o);
      if (arr_req_o && wb_req_o) proto_err++;
      if (ack_c < 0 && c >= 1 && !busy_o) proto_err++;
      if (ack_c >= 0 && c > ack_c && (busy_o || arr_req_o || wb_req_o)) proto_err++;
      if (arr_req_o) begin
        if (stall_cnt == 0) begin
          ref_idx = cur;
          ref_we  = arr_we_o;
        end else if (cur != ref_idx || arr_we_o != ref_we) begin
          stab_err++;
        end
        if (stall_cnt < v.stall) begin
          stall_cnt++;
        end else begin
          arr_gnt_i = 1'b1;
          stall_cnt = 0;
          if (arr_we_o) begin
            invs++;
            exp_i = -1;
            for (int k = inv_ptr; k < N; k++) if (v.valid[k] && exp_i < 0) exp_i = k;
            if (cur != exp_i) order_err++;
            if (v.dirty[cur] && !committed[cur]) order_err++;
            inv_ptr = cur + 1;
            mv[cur] = 1'b0;
            md[cur] = 1'b0;
          end else begin
            if (cur != rd_ptr) order_err++;
            rd_ptr  = cur + 1;
            rd_pend = 1'b1;
            rd_idx  = cur;
          end
        end
      end
      if (wb_req_o) begin
        wb_gnt_i = 1'b1;
        wbs++;
        exp_i = -1;
        for (int k = wb_ptr; k < N; k++) if (v.valid[k] && v.dirty[k] && exp_i < 0) exp_i = k;
        if (wcur != exp_i || wb_tag_o !== mt[wcur]) order_err++;
        wb_ptr   = wcur + 1;
        wb_line  = wcur;
        done_act = 1'b1;
        done_cnt = v.lat;
      end
      if (done_act) begin
        if (done_cnt == 0) begin
          wb_done_i = 1'b1;
          done_act  = 1'b0;
          committed[wb_line] = 1'b1;
        end else begin
          done_cnt--;
        end
      end
      if (flush_ack_o) begin
        acks++;
        if (ack_c < 0) ack_c = c;
      end
      // Keep flush_i high through the HOLD cycle following the ack.
      if (ack_c >= 0 && c == ack_c + 2) flush_i = 1'b0;
      if (ack_c >= 0 && c == ack_c + 6) break;
      @(negedge clk_i);
      c++;
    end
    flush_i = 1'b0; arr_gnt_i = 1'b0; wb_gnt_i = 1'b0; wb_done_i = 1'b0;
    arr_rvalid_i = 1'b0; arr_rdirty_i = 1'b0; arr_rtag_i = '0;
    for (int i = 0; i < N; i++) final_valid[i] = mv[i];
    tag = $sformatf("v%0d", id);
    chk({tag, "_ack_cycle"}, 64'(ack_c), 64'(v.exp_ack));
    chk({tag, "_ack_pulses"}, 64'(acks), 64'd1);
    chk({tag, "_wb_count"}, 64'(wbs), 64'(v.exp_wbs));
    chk({tag, "_inv_count"}, 64'(invs), 64'(v.exp_invs));
    chk({tag, "_order"}, 64'(order_err), 64'd0);
    chk({tag, "_stable"}, 64'(stab_err), 64'd0);
    chk({tag, "_protocol"}, 64'(proto_err), 64'd0);
    chk({tag, "_all_invalid"}, 64'(final_valid), 64'd0);
`ifdef DCACHE_FLUSH_PERF_EN
    chk({tag, "_perf_wb"}, 64'(perf_wb_cnt_o), 64'(v.exp_wbs));
    chk({tag, "_perf_cycles"}, 64'(perf_cycles_o), 64'(v.exp_ack));
`endif
  endtask

  initial begin
    int acks;
    //          valid    dirty    tag_base  stall lat ack wbs invs
    vecs[0] = '{4'b0000, 4'b0000, 44'h0,    0,    0,  9,  0,  0};
    vecs[1] = '{4'b0100, 4'b0100, 44'hABA,  0,    5,  16, 1,  1};
    vecs[2] = '{4'b1111, 4'b0000, 44'h100,  0,    0,  13, 0,  4};
    vecs[3] = '{4'b0000, 4'b0000, 44'h0,    3,    0,  21, 0,  0};
    vecs[4] = '{4'b1011, 4'b1011, 44'h777,  0,    0,  15, 3,  3};
    vecs[5] = '{4'b0010, 4'b0000, 44'h3C0,  3,    0,  25, 0,  1};

    rst_i = 1'b1; flush_i = 1'b0; arr_gnt_i = 1'b0; wb_gnt_i = 1'b0; wb_done_i = 1'b0;
    arr_rvalid_i = 1'b0; arr_rdirty_i = 1'b0; arr_rtag_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_ctrl", 64'({flush_ack_o, busy_o, arr_req_o, arr_we_o, wb_req_o}), 64'd0);
    chk("reset_addr", 64'({arr_set_o, arr_way_o, wb_set_o, wb_way_o}), 64'd0);
    chk("reset_tag", 64'(wb_tag_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Back-to-back flushes also cover re-flush after HOLD restarting at index 0.
    for (int i = 0; i < 6; i++) run_flush(vecs[i], i);

    // Reset while waiting for a writeback commit.
    @(negedge clk_i);
    flush_i = 1'b1; arr_gnt_i = 1'b1; wb_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("rst_seq_rd", 64'(arr_req_o), 64'd1);
    @(negedge clk_i);
    arr_rvalid_i = 1'b1; arr_rdirty_i = 1'b1; arr_rtag_i = 44'h5A5;
    @(negedge clk_i);
    arr_rvalid_i = 1'b0; arr_rdirty_i = 1'b0; arr_rtag_i = '0;
    chk("rst_seq_wb", 64'({wb_req_o, wb_tag_o}), {19'd0, 1'b1, 44'h5A5});
    @(negedge clk_i);
    chk("rst_seq_wbwait", 64'({busy_o, wb_req_o, arr_req_o}), 64'b100);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; flush_i = 1'b0; arr_gnt_i = 1'b0; wb_gnt_i = 1'b0;
    chk("rst_seq_ctrl", 64'({flush_ack_o, busy_o, arr_req_o, arr_we_o, wb_req_o}), 64'd0);
    chk("rst_seq_tag", 64'(wb_tag_o), 64'd0);
    acks = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (flush_ack_o || busy_o) acks++;
    end
    chk("rst_seq_no_ack", 64'(acks), 64'd0);

    run_flush(vecs[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
